// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: next-PC select
// encodings, the default boot address and the fetch FSM state encodings.
package inst_fetch_pkg;

    // Boot vector used when the RESET_PC parameter is left at its default
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

    // Next-PC select encodings driven by decode
    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BPC  = 2'b01;
    localparam logic [1:0] PCSRC_JRPC = 2'b10;
    localparam logic [1:0] PCSRC_JPC  = 2'b11;

    // Fetch FSM states
    localparam logic [0:0] ST_REQ  = 1'b0;  // request may be issued
    localparam logic [0:0] ST_WAIT = 1'b1;  // request accepted, awaiting data

    // Sequential successor, modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_npc_sel.sv
// Next-PC selection: picks the sequential successor or one of the
// branch/jump targets according to pcsource. Purely combinational.
module npc_sel
    import inst_fetch_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    output logic [31:0] target
);

    // Select the target for the instruction being consumed
    always_comb begin
        target = pc_plus4(fetch_pc);
        unique case (pcsource)
            PCSRC_SEQ:  target = pc_plus4(fetch_pc);
            PCSRC_BPC:  target = bpc;
            PCSRC_JRPC: target = jrpc;
            PCSRC_JPC:  target = jpc;
            default:    target = pc_plus4(fetch_pc);
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one request at a time on an SRAM-like
// instruction bus, buffers one fetched instruction for decode, and applies
// branch/jump redirects after the delay slot.
// Optional feature macro: FETCH_ADEL_CHECK_EN -- misaligned fetch addresses
// are not sent to the bus; a flagged pseudo-instruction (o_adel) is delivered
// instead and fetch halts until decode redirects to a new address.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] jrpc,
    input  logic        id_stall,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        o_adel
);

    logic [0:0]  state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] req_pc_reg;       // address of the outstanding request
    logic [31:0] redirect_pc_reg;
    logic        pending_reg;
    logic [31:0] o_inst_reg;
    logic [31:0] o_pc_reg;
    logic        o_valid_reg;

    logic        consume;
    logic        redirect_now;
    logic        buf_free;
    logic        addr_accept;
    logic        data_accept;
    logic        misaligned;
    logic        direct_load;
    logic        adel_issue;
    logic [31:0] npc_target;
    logic [31:0] launch_pc;

    npc_sel u_npc_sel (
        .pcsource (pcsource),
        .fetch_pc (fetch_pc_reg),
        .bpc      (bpc),
        .jrpc     (jrpc),
        .jpc      (jpc),
        .target   (npc_target)
    );

    assign consume      = o_valid_reg && !id_stall;
    assign redirect_now = consume && (pcsource != PCSRC_SEQ);
    // The output buffer can take a new entry if empty or being emptied now
    assign buf_free     = !o_valid_reg || consume;
    assign inst_req     = !reset && (state_reg == ST_REQ) && buf_free && !misaligned;
    assign inst_addr    = fetch_pc_reg;
    assign addr_accept  = inst_req && inst_addr_ok;
    assign data_accept  = (state_reg == ST_WAIT) && inst_data_ok;
    // A halted (misaligned) fetch is restarted by loading the target directly,
    // since there is no delay-slot fetch to wait for
    assign direct_load  = (state_reg == ST_REQ) && misaligned;
    // Address following the one just accepted: a redirect this cycle wins
    // over a pending one, otherwise sequential
    assign launch_pc    = redirect_now ? npc_target :
                          pending_reg  ? redirect_pc_reg : pc_plus4(fetch_pc_reg);

`ifdef FETCH_ADEL_CHECK_EN
    logic adel_reg;
    logic adel_sent_reg;

    assign misaligned = (fetch_pc_reg[1:0] != 2'b00);
    assign adel_issue = direct_load && buf_free && !adel_sent_reg && !redirect_now;
    assign o_adel     = adel_reg;

    // Address-error flag travels with the buffered entry; deliver it only once
    always_ff @(posedge clk) begin
        if (reset) begin
            adel_reg      <= 1'b0;
            adel_sent_reg <= 1'b0;
        end else begin
            if (data_accept) begin
                adel_reg <= 1'b0;
            end else if (adel_issue) begin
                adel_reg <= 1'b1;
            end else if (consume) begin
                adel_reg <= 1'b0;
            end
            if (redirect_now && direct_load) begin
                adel_sent_reg <= 1'b0;
            end else if (adel_issue) begin
                adel_sent_reg <= 1'b1;
            end
        end
    end
`else
    assign misaligned = 1'b0;
    assign adel_issue = 1'b0;
    assign o_adel     = 1'b0;
`endif

    // Fetch FSM, fetch PC and redirect bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_REQ;
            fetch_pc_reg    <= RESET_PC;
            req_pc_reg      <= 32'd0;
            redirect_pc_reg <= 32'd0;
            pending_reg     <= 1'b0;
        end else if (addr_accept) begin
            state_reg    <= ST_WAIT;
            req_pc_reg   <= fetch_pc_reg;
            fetch_pc_reg <= launch_pc;
            pending_reg  <= 1'b0;
        end else begin
            if (data_accept) begin
                state_reg <= ST_REQ;
            end
            if (redirect_now) begin
                if (direct_load) begin
                    fetch_pc_reg <= npc_target;
                    pending_reg  <= 1'b0;
                end else begin
                    redirect_pc_reg <= npc_target;
                    pending_reg     <= 1'b1;
                end
            end
        end
    end

    // One-entry output buffer towards decode
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid_reg <= 1'b0;
            o_inst_reg  <= 32'd0;
            o_pc_reg    <= 32'd0;
        end else if (data_accept) begin
            o_valid_reg <= 1'b1;
            o_inst_reg  <= inst_rdata;
            o_pc_reg    <= req_pc_reg;
        end else if (adel_issue) begin
            o_valid_reg <= 1'b1;
            o_inst_reg  <= 32'd0;
            o_pc_reg    <= fetch_pc_reg;
        end else if (consume) begin
            o_valid_reg <= 1'b0;
        end
    end

    assign o_valid = o_valid_reg;
    assign o_inst  = o_inst_reg;
    assign o_pc    = o_pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a bus model and a decode model drive the DUT;
// expected deliveries and expected bus addresses are queued by the stimulus
// and popped/compared by independent monitor processes.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0;
    logic [31:0] jpc = 32'd0;
    logic [31:0] jrpc = 32'd0;
    logic        id_stall = 1'b1;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        o_adel;

    item_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // Bench-side knobs
    logic [31:0] br_pc = 32'h1;
    logic [1:0]  br_src = 2'b00;
    int          data_delay = 0;
    logic        hold_arm = 1'b0;
    logic [31:0] hold_addr = 32'd0;
    int          hold_left = 0;

    inst_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .pcsource     (pcsource),
        .bpc          (bpc),
        .jpc          (jpc),
        .jrpc         (jrpc),
        .id_stall     (id_stall),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .o_adel       (o_adel)
    );

    always #5 clk = ~clk;

    // Bus slave refuses the held address for a few cycles, accepts otherwise
    assign inst_addr_ok = !((hold_left > 0) || (hold_arm && inst_req && inst_addr == hold_addr));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h24010001;
        return a ^ 32'h5555AAAA;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    function automatic item_t mk(input logic [31:0] pc);
        item_t it;
        it.pc = pc;
        it.inst = mem_word(pc);
        it.adel = 1'b0;
        return it;
    endfunction

    // Bus model: checks every accepted address, returns data after data_delay
    initial begin : bus
        int dcnt;
        logic [31:0] cap;
        logic acc;
        logic [31:0] acc_addr;
        logic [31:0] want;
        dcnt = -1;
        cap = 32'd0;
        forever begin
            @(negedge clk);
            acc = inst_req && inst_addr_ok;
            acc_addr = inst_addr;
            if (hold_left > 0) begin
                check("hold_req", 32'(inst_req), 32'd1);
                check("hold_addr", inst_addr, hold_addr);
            end
            if (hold_arm && inst_req && inst_addr == hold_addr) begin
                hold_arm = 1'b0;
                hold_left = 4;
            end
            if (acc) begin
                if (exp_addr_q.size() == 0) begin
                    fail_now("accept_unexpected", acc_addr);
                end else begin
                    want = exp_addr_q.pop_front();
                    check("accept_addr", acc_addr, want);
                end
            end
            @(posedge clk);
            #1;
            if (hold_left > 0) hold_left--;
            if (inst_data_ok) dcnt = -1;
            if (acc) begin
                dcnt = data_delay;
                cap = acc_addr;
            end else if (dcnt > 0) begin
                dcnt--;
            end
            inst_data_ok = (dcnt == 0);
            inst_rdata = (dcnt == 0) ? mem_word(cap) : 32'hDEADBEEF;
        end
    end

    // Decode model: redirects when the designated instruction is presented
    initial begin : decode
        forever begin
            @(posedge clk);
            #1;
            pcsource = (o_valid && o_pc == br_pc) ? br_src : 2'b00;
        end
    end

    // Delivery monitor: pops on consume, checks hold while stalled
    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (!reset && o_valid) begin
                if (id_stall) begin
                    check("stall_req", 32'(inst_req), 32'd0);
                    if (exp_q.size() != 0) begin
                        check("stall_pc", o_pc, exp_q[0].pc);
                        check("stall_inst", o_inst, exp_q[0].inst);
                    end
                end else if (exp_q.size() == 0) begin
                    fail_now("deliver_unexpected", o_pc);
                end else begin
                    it = exp_q.pop_front();
                    check("deliver_pc", o_pc, it.pc);
                    check("deliver_inst", o_inst, it.inst);
                    check("deliver_adel", 32'(o_adel), 32'(it.adel));
                end
            end
        end
    end

    task automatic reset_begin();
        @(posedge clk);
        #1;
        id_stall = 1'b1;
        reset = 1'b1;
        hold_arm = 1'b0;
        hold_left = 0;
        br_pc = 32'h1;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        check("rst_req_first", 32'(inst_req), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_pc", o_pc, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_adel", 32'(o_adel), 32'd0);
        check("rst_req", 32'(inst_req), 32'd0);
    endtask

    task automatic reset_end();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("boot_req", 32'(inst_req), 32'd1);
        check("boot_addr", inst_addr, RST_PC);
    endtask

    task automatic run_drain(input bit stall_after);
        int t;
        @(posedge clk);
        #1;
        id_stall = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout", 32'(exp_q.size()));
        if (stall_after) begin
            @(posedge clk);
            #1;
            id_stall = 1'b1;
            repeat (8) @(negedge clk);
            check("addr_left", 32'(exp_addr_q.size()), 32'd0);
        end
    endtask

    task automatic push_seq(input logic [31:0] pcs[$], input logic [31:0] addrs[$]);
        foreach (pcs[i]) exp_q.push_back(mk(pcs[i]));
        foreach (addrs[i]) exp_addr_q.push_back(addrs[i]);
    endtask

    initial begin : main
        // Boot, first-fetch latency, stall hold, sequential fetch
        data_delay = 0;
        reset_begin();
        push_seq('{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C},
                 '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00010});
        reset_end();
        @(negedge clk);
        @(negedge clk);
        check("first_valid", 32'(o_valid), 32'd1);
        check("first_pc", o_pc, RST_PC);
        check("first_inst", o_inst, 32'h24010001);
        repeat (3) @(negedge clk);
        run_drain(1'b1);

        // Branch via bpc, redirect coincides with delay-slot acceptance
        reset_begin();
        bpc = 32'hBFC00100; jpc = 32'hBFC00300; jrpc = 32'hBFC00400;
        br_pc = 32'hBFC00008; br_src = 2'b01;
        push_seq('{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00100},
                 '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00100, 32'hBFC00104});
        reset_end();
        run_drain(1'b1);

        // Same branch with the delay-slot request held off by the bus
        reset_begin();
        br_pc = 32'hBFC00008; br_src = 2'b01;
        hold_addr = 32'hBFC0000C; hold_arm = 1'b1;
        push_seq('{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00100},
                 '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00100, 32'hBFC00104});
        reset_end();
        run_drain(1'b1);

        // Jump via jpc with one data wait state
        data_delay = 1;
        reset_begin();
        bpc = 32'hBFC00500; jpc = 32'hBFC00200; jrpc = 32'hBFC00600;
        br_pc = 32'hBFC00004; br_src = 2'b11;
        push_seq('{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00200},
                 '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00200, 32'hBFC00204});
        reset_end();
        run_drain(1'b1);

        // jr near the top of the address space: PC wraps to zero
        data_delay = 2;
        reset_begin();
        jrpc = 32'hFFFFFFF8;
        br_pc = 32'hBFC00004; br_src = 2'b10;
        push_seq('{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000},
                 '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004});
        reset_end();
        run_drain(1'b1);

        // Reset while waiting for data; the late data beat must be discarded
        data_delay = 2;
        reset_begin();
        push_seq('{32'hBFC00000}, '{32'hBFC00000, 32'hBFC00000});
        reset_end();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_req", 32'(inst_req), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("late_data_seen", 32'(inst_data_ok), 32'd1);
        check("refetch_req", 32'(inst_req), 32'd1);
        check("refetch_addr", inst_addr, RST_PC);
        @(negedge clk);
        check("late_data_valid", 32'(o_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("refetch_valid", 32'(o_valid), 32'd1);
        check("refetch_pc", o_pc, RST_PC);
        check("addr_left", 32'(exp_addr_q.size()), 32'd0);

`ifdef FETCH_ADEL_CHECK_EN
        // Misaligned jr target: delay slot delivered, then the address error
        data_delay = 0;
        reset_begin();
        jrpc = 32'hBFC00102;
        br_pc = 32'hBFC00004; br_src = 2'b10;
        push_seq('{32'hBFC00000, 32'hBFC00004, 32'hBFC00008},
                 '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008});
        exp_q.push_back('{pc: 32'hBFC00102, inst: 32'd0, adel: 1'b1});
        reset_end();
        run_drain(1'b0);
        repeat (10) @(negedge clk);
        check("adel_halt_valid", 32'(o_valid), 32'd0);
        check("adel_halt_req", 32'(inst_req), 32'd0);
        check("addr_left", 32'(exp_addr_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge; reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: pcsource  in  2  next-PC select from decode (00 pc+4, 01 bpc, 10 jrpc, 11 jpc); bpc, jpc, jrpc  in  32 each  branch/jump/register targets.
REQ-004 SHALL have ports: id_stall  in  1  decode cannot accept; o_inst  out  32  fetched instruction; o_pc  out  32  its address; o_valid  out  1  o_inst/o_pc valid.
REQ-005 SHALL have ports: inst_req  out  1; inst_addr  out  32; inst_addr_ok  in  1; inst_data_ok  in  1; inst_rdata  in  32 (SRAM-like instruction bus, one outstanding request).
REQ-006 SHALL have port o_adel  out  1  fetch address-error flag (see Configuration).

Function
REQ-007 Consume event SHALL be o_valid && !id_stall; pcsource and targets are sampled only in a consume cycle and refer to the instruction being consumed.
REQ-008 FSM states: REQ (inst_req may assert), WAIT (request accepted, awaiting data); reset state REQ.
REQ-009 In REQ, inst_req SHALL be 1 exactly when (!o_valid || consume); inst_addr = fetch_pc, held stable until inst_addr_ok.
REQ-010 REQ && inst_req && inst_addr_ok -> WAIT; fetch_pc SHALL advance to redirect target if a redirect is pending or occurs this cycle, else fetch_pc+4; pending cleared.
REQ-011 WAIT && inst_data_ok -> REQ; o_inst <= inst_rdata, o_pc <= address of that request, o_valid <= 1, same edge.
REQ-012 On consume without new data, o_valid SHALL drop to 0 next cycle; o_inst/o_pc hold while id_stall=1.
REQ-013 Consume with pcsource != 00 SHALL record the selected target in redirect register and set pending; delay slot (fetch_pc at that moment) is still fetched and delivered.
REQ-014 Redirect and inst_addr_ok in the same cycle: the accepted address is the delay slot, the target SHALL be the next fetch_pc, pending not left set.
REQ-015 Second redirect while pending SHALL NOT occur architecturally; if it does, the newer target overwrites.
REQ-016 inst_data_ok outside WAIT SHALL be ignored; inst_addr_ok while inst_req=0 SHALL be ignored.
REQ-017 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-018 Throughput SHALL be one instruction per two cycles with zero-wait bus (addr_ok and data_ok each one cycle).

Reset
REQ-019 On reset: state REQ, fetch_pc=RESET_PC, pending=0, o_valid=0, o_inst=0, o_pc=0, o_adel=0, inst_req=0 during reset cycle.
REQ-020 First cycle after reset deassert SHALL drive inst_req=1, inst_addr=RESET_PC.
REQ-021 Reset mid-transaction SHALL abandon the outstanding request; a late inst_data_ok is discarded per REQ-016.

Configuration
REQ-022 Macro FETCH_ADEL_CHECK_EN: when defined, fetch_pc[1:0]!=0 in REQ SHALL NOT assert inst_req; instead when buffer free, o_valid=1, o_inst=0, o_pc=fetch_pc, o_adel=1, fetch halts until a consumed redirect supplies an aligned fetch_pc.
REQ-023 Without FETCH_ADEL_CHECK_EN, o_adel SHALL be constant 0 and inst_addr is issued unmodified.

Structure
REQ-024 pcsource encodings, RESET_PC default and FSM state encodings SHALL live in the shared global define header.
REQ-025 Next-PC selection SHALL be a sub-module npc_sel (pcsource, fetch_pc, bpc, jrpc, jpc -> target); all state stays in inst_fetch.

Verification
REQ-026 Reset then zero-wait bus returning 32'h24010001 -> inst_addr=BFC00000, o_valid=1 with o_pc=BFC00000 two cycles after first inst_req.
REQ-027 Sequential fetch, id_stall=0, 4 instructions -> o_pc BFC00000,04,08,0C; id_stall=1 for 3 cycles holds o_pc/o_inst, inst_req=0.
REQ-028 Consume at BFC00008 with pcsource=01, bpc=BFC00100 -> delivered o_pc BFC0000C then BFC00100.
REQ-029 Same as REQ-028 but inst_addr_ok delayed 4 cycles -> inst_addr stays BFC0000C, next request BFC00100.
REQ-030 FETCH_ADEL_CHECK_EN, jr with jrpc=BFC00102 -> delay slot delivered, then o_adel=1, o_pc=BFC00102, o_inst=0, no inst_req.
REQ-031 reset asserted while WAIT, inst_data_ok arrives one cycle after deassert -> o_valid stays 0, next inst_addr=BFC00000.
